// File: rtl/oled_spi_receiver.sv
// SSD1306-style 4-wire SPI target: byte deserialiser, command parser and framebuffer write port.
// Optional feature: define OLED_RX_ADDR_WINDOW_EN to let 0x21/0x22 set the column/page window.
module oled_spi_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ioSclk,
  input  logic       ioSdin,
  input  logic       ioCs,
  input  logic       ioDc,
  input  logic       ioReset,
  output logic       pixelWrite,
  output logic [9:0] pixelAddress,
  output logic [7:0] pixelData,
  output logic       cmdStrobe,
  output logic [7:0] cmdByte,
  output logic       displayOn,
  output logic       inverted,
  output logic       allOn,
  output logic [7:0] contrast,
  output logic [5:0] startLine
);
  typedef enum logic [1:0] {ST_OPCODE, ST_ARG1, ST_ARG2} state_e;

  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D: is_one_arg = 1'b1;
      default: is_one_arg = 1'b0;
    endcase
  endfunction

  function automatic logic is_two_arg(input logic [7:0] op);
    is_two_arg = (op == 8'h21) || (op == 8'h22);
  endfunction

  // Input synchronisers; only the external reset initialises them so ioReset can't lock itself out.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, cs_sync_q, dc_sync_q, rstn_sync_q;
  logic                   sclk_prev_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{1'b1}};
      sdin_sync_q <= '0;
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      dc_sync_q   <= '0;
      rstn_sync_q <= {SYNC_STAGES{1'b1}};
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ioSclk};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], ioSdin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ioCs};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], ioDc};
      rstn_sync_q <= {rstn_sync_q[SYNC_STAGES-2:0], ioReset};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, sdin_s, cs_s, dc_s, rst_int, bit_en;
  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s  = sdin_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign dc_s    = dc_sync_q[SYNC_STAGES-1];
  assign rst_int = reset | ~rstn_sync_q[SYNC_STAGES-1];
  assign bit_en  = sclk_s & ~sclk_prev_q & ~cs_s;

  // Deserialiser: completed byte is registered with its dc flag
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_dc_q, byte_vld_q;
  always_ff @(posedge clk) begin
    if (rst_int) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      byte_dc_q  <= 1'b0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (bit_en) begin
        shift_q   <= {shift_q[5:0], sdin_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q     <= {shift_q, sdin_s};
          byte_dc_q  <= dc_s;
          byte_vld_q <= 1'b1;
        end
      end
    end
  end

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       pix_wr_q, pix_wr_d, cmd_stb_q, cmd_stb_d;
  logic [9:0] pix_addr_q, pix_addr_d;
  logic [7:0] pix_data_q, pix_data_d, cmd_byte_q, cmd_byte_d, contrast_q, contrast_d;
  logic       disp_on_q, disp_on_d, inv_q, inv_d, all_on_q, all_on_d;
  logic [5:0] start_line_q, start_line_d;
  logic [6:0] col_q, col_d, col_start, col_end;
  logic [2:0] page_q, page_d, page_start, page_end;

`ifdef OLED_RX_ADDR_WINDOW_EN
  function automatic logic [6:0] clamp_col(input logic [6:0] s, input logic [6:0] e);
    clamp_col = (e < s) ? s : e;
  endfunction

  function automatic logic [2:0] clamp_page(input logic [2:0] s, input logic [2:0] e);
    clamp_page = (e < s) ? s : e;
  endfunction

  logic [7:0] arg_q, arg_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_start_q, page_start_d, page_end_q, page_end_d;
  assign col_start  = col_start_q;
  assign col_end    = col_end_q;
  assign page_start = page_start_q;
  assign page_end   = page_end_q;
`else
  assign col_start  = 7'd0;
  assign col_end    = 7'd127;
  assign page_start = 3'd0;
  assign page_end   = 3'd7;
`endif

  // Parser: state register
  always_ff @(posedge clk) begin
    if (rst_int) begin
      state_q      <= ST_OPCODE;
      op_q         <= '0;
      pix_wr_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      cmd_stb_q    <= 1'b0;
      cmd_byte_q   <= '0;
      disp_on_q    <= 1'b0;
      inv_q        <= 1'b0;
      all_on_q     <= 1'b0;
      contrast_q   <= 8'h7F;
      start_line_q <= '0;
      col_q        <= '0;
      page_q       <= '0;
`ifdef OLED_RX_ADDR_WINDOW_EN
      arg_q        <= '0;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      pix_wr_q     <= pix_wr_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      cmd_stb_q    <= cmd_stb_d;
      cmd_byte_q   <= cmd_byte_d;
      disp_on_q    <= disp_on_d;
      inv_q        <= inv_d;
      all_on_q     <= all_on_d;
      contrast_q   <= contrast_d;
      start_line_q <= start_line_d;
      col_q        <= col_d;
      page_q       <= page_d;
`ifdef OLED_RX_ADDR_WINDOW_EN
      arg_q        <= arg_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
`endif
    end
  end

  // Parser: next state; a data byte always returns to OPCODE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    if (byte_vld_q) begin
      if (byte_dc_q) begin
        state_d = ST_OPCODE;
      end else begin
        case (state_q)
          ST_OPCODE: begin
            op_d = byte_q;
            if (is_one_arg(byte_q) || is_two_arg(byte_q)) state_d = ST_ARG1;
          end
          ST_ARG1: state_d = is_two_arg(op_q) ? ST_ARG2 : ST_OPCODE;
          default: state_d = ST_OPCODE;
        endcase
      end
    end
  end

  // Parser: outputs, settings and address pointer
  always_comb begin
    pix_wr_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    cmd_stb_d    = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    disp_on_d    = disp_on_q;
    inv_d        = inv_q;
    all_on_d     = all_on_q;
    contrast_d   = contrast_q;
    start_line_d = start_line_q;
    col_d        = col_q;
    page_d       = page_q;
`ifdef OLED_RX_ADDR_WINDOW_EN
    arg_d        = arg_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
`endif
    if (byte_vld_q && byte_dc_q) begin
      pix_wr_d   = 1'b1;
      pix_addr_d = {page_q, col_q};
      pix_data_d = byte_q;
      if (col_q == col_end) begin
        col_d  = col_start;
        page_d = (page_q == page_end) ? page_start : page_q + 3'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (byte_vld_q) begin
      cmd_stb_d  = 1'b1;
      cmd_byte_d = byte_q;
      case (state_q)
        ST_OPCODE: begin
          case (byte_q)
            8'hAE, 8'hAF: disp_on_d = byte_q[0];
            8'hA6, 8'hA7: inv_d     = byte_q[0];
            8'hA4, 8'hA5: all_on_d  = byte_q[0];
            default: if (byte_q[7:6] == 2'b01) start_line_d = byte_q[5:0];
          endcase
        end
        ST_ARG1: begin
          if (op_q == 8'h81) contrast_d = byte_q;
`ifdef OLED_RX_ADDR_WINDOW_EN
          arg_d = byte_q;
`endif
        end
        default: begin
`ifdef OLED_RX_ADDR_WINDOW_EN
          if (op_q == 8'h21) begin
            col_start_d = arg_q[6:0];
            col_end_d   = clamp_col(arg_q[6:0], byte_q[6:0]);
            col_d       = arg_q[6:0];
          end else begin
            page_start_d = arg_q[2:0];
            page_end_d   = clamp_page(arg_q[2:0], byte_q[2:0]);
            page_d       = arg_q[2:0];
          end
`endif
        end
      endcase
    end
  end

  assign pixelWrite   = pix_wr_q;
  assign pixelAddress = pix_addr_q;
  assign pixelData    = pix_data_q;
  assign cmdStrobe    = cmd_stb_q;
  assign cmdByte      = cmd_byte_q;
  assign displayOn    = disp_on_q;
  assign inverted     = inv_q;
  assign allOn        = all_on_q;
  assign contrast     = contrast_q;
  assign startLine    = start_line_q;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: commands, pixel streaming, framing and reset behaviour.
module tb_oled_spi_receiver;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset, ioSclk, ioSdin, ioCs, ioDc, ioReset;
  logic       pixelWrite, cmdStrobe, displayOn, inverted, allOn;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData, cmdByte, contrast;
  logic [5:0] startLine;

  int errors = 0;
  int checks = 0;

  logic [9:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] cmd_q[$];

  always #5 clk = ~clk;

  oled_spi_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .ioSclk(ioSclk), .ioSdin(ioSdin), .ioCs(ioCs),
    .ioDc(ioDc), .ioReset(ioReset), .pixelWrite(pixelWrite), .pixelAddress(pixelAddress),
    .pixelData(pixelData), .cmdStrobe(cmdStrobe), .cmdByte(cmdByte), .displayOn(displayOn),
    .inverted(inverted), .allOn(allOn), .contrast(contrast), .startLine(startLine)
  );

  always @(negedge clk) begin
    if (pixelWrite) begin
      wa_q.push_back(pixelAddress);
      wd_q.push_back(pixelData);
    end
    if (cmdStrobe) cmd_q.push_back(cmdByte);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      ioSclk = 1'b0; ioSdin = b[i]; ioDc = dc;
      tick(2);
      ioSclk = 1'b1;
      tick(2);
    end
  endtask

  task automatic send_framed(input logic dc, input logic [7:0] b);
    ioCs = 1'b0;
    tick(3);
    send_bits(dc, b, 8);
    tick(4);
    ioCs = 1'b1;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    wa_q.delete(); wd_q.delete(); cmd_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] exp_addr [5];
    int bad, first_bad, n;

    reset = 1'b1; ioSclk = 1'b1; ioSdin = 1'b0; ioCs = 1'b1; ioDc = 1'b0; ioReset = 1'b1;
    tick(3);
    chk("rst_pixelWrite", pixelWrite, 0);
    chk("rst_cmdStrobe", cmdStrobe, 0);
    chk("rst_pixelAddress", pixelAddress, 0);
    chk("rst_contrast", contrast, 8'h7F);
    chk("rst_flags", {displayOn, inverted, allOn}, 3'b000);
    chk("rst_cmdByte_startLine", {cmdByte, startLine}, 0);
    reset = 1'b0;
    tick(2);

    // Commands with cs raised between bytes
    send_framed(1'b0, 8'hAE);
    send_framed(1'b0, 8'h81);
    send_framed(1'b0, 8'h3C);
    send_framed(1'b0, 8'hAF);
    chk("t1_cmd_count", cmd_q.size(), 4);
    chk("t1_cmd0", cmd_q[0], 8'hAE);
    chk("t1_cmd1", cmd_q[1], 8'h81);
    chk("t1_cmd2", cmd_q[2], 8'h3C);
    chk("t1_cmd3", cmd_q[3], 8'hAF);
    chk("t1_contrast", contrast, 8'h3C);
    chk("t1_displayOn", displayOn, 1);
    send_framed(1'b0, 8'h5A);
    chk("t1_startLine", startLine, 6'h1A);

    // 1025 data bytes with cs held low
    do_reset();
    ioCs = 1'b0;
    tick(3);
    for (int i = 0; i < 1025; i++) begin
      b = i[7:0];
      send_bits(1'b1, b, 8);
    end
    tick(6);
    ioCs = 1'b1;
    tick(4);
    n = wa_q.size();
    chk("t2_write_count", n, 1025);
    bad = 0; first_bad = -1;
    for (int i = 0; i < n; i++) begin
      if (wa_q[i] !== 10'(i % 1024) || wd_q[i] !== 8'(i % 256)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk("t2_seq_bad_entries", bad, 0);
    chk("t2_last_addr", wa_q[$], 10'd0);
    chk("t2_last_data", wd_q[$], 8'h00);
    chk("t2_cmd_count", cmd_q.size(), 0);

    // Partial byte dropped by cs, then a full A7
    do_reset();
    ioCs = 1'b0;
    tick(3);
    send_bits(1'b0, 8'hC3, 5);
    tick(2);
    ioCs = 1'b1;
    tick(4);
    send_framed(1'b0, 8'hA7);
    chk("t3_cmd_count", cmd_q.size(), 1);
    chk("t3_cmd0", cmd_q[0], 8'hA7);
    chk("t3_cmdByte", cmdByte, 8'hA7);
    chk("t3_inverted", inverted, 1);

    // Data byte aborts a pending 0x81 argument; check strobe latency
    do_reset();
    ioCs = 1'b0;
    tick(3);
    send_bits(1'b0, 8'h81, 8);
    tick(4);
    b = 8'h55;
    send_bits(1'b1, b, 7);
    ioSclk = 1'b0; ioSdin = b[0]; ioDc = 1'b1;
    tick(2);
    ioSclk = 1'b1;
    tick(SYNC_STAGES + 1);
    chk("t4_strobe_not_early", pixelWrite, 0);
    tick(1);
    chk("t4_strobe_on_time", pixelWrite, 1);
    chk("t4_addr", pixelAddress, 10'd0);
    chk("t4_data", pixelData, 8'h55);
    tick(1);
    chk("t4_strobe_one_cycle", pixelWrite, 0);
    tick(2);
    send_bits(1'b0, 8'hA5, 8);
    tick(6);
    ioCs = 1'b1;
    tick(4);
    chk("t4_contrast", contrast, 8'h7F);
    chk("t4_allOn", allOn, 1);
    chk("t4_write_count", wa_q.size(), 1);

    // Address window commands then five data bytes
    do_reset();
`ifdef OLED_RX_ADDR_WINDOW_EN
    exp_addr = '{10'd272, 10'd273, 10'd400, 10'd401, 10'd272};
`else
    exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
`endif
    send_framed(1'b0, 8'h21);
    send_framed(1'b0, 8'h10);
    send_framed(1'b0, 8'h11);
    send_framed(1'b0, 8'h22);
    send_framed(1'b0, 8'h02);
    send_framed(1'b0, 8'h03);
    ioCs = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) send_bits(1'b1, 8'hE0 + 8'(i), 8);
    tick(6);
    ioCs = 1'b1;
    tick(4);
    chk("t5_write_count", wa_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t5_addr%0d", i), wa_q[i], exp_addr[i]);

    // ioReset pulse mid-byte restores defaults and discards the partial byte
    do_reset();
    send_framed(1'b0, 8'h81);
    send_framed(1'b0, 8'h3C);
    chk("t6_contrast_set", contrast, 8'h3C);
    cmd_q.delete();
    ioCs = 1'b0;
    tick(3);
    send_bits(1'b0, 8'hF0, 4);
    ioReset = 1'b0;
    tick(3);
    ioReset = 1'b1;
    tick(4);
    chk("t6_contrast_reset", contrast, 8'h7F);
    chk("t6_displayOn_reset", displayOn, 0);
    send_bits(1'b0, 8'hAF, 8);
    tick(6);
    ioCs = 1'b1;
    tick(4);
    chk("t6_cmd_count", cmd_q.size(), 1);
    chk("t6_cmd0", cmd_q[0], 8'hAF);
    chk("t6_displayOn", displayOn, 1);
    chk("t6_contrast_kept", contrast, 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
